// File: rtl/pipe_acc_tree.sv
// pipe_acc_tree: registered pairwise adder tree feeding a windowed, optionally saturating accumulator.
// Latency: a sample captured at edge k is accumulated at edge k+log2(N_IN); the window result pulses the cycle after its last add.
// Backpressure: none; one sample per cycle is always accepted, and in_valid gaps simply pause the window.
module pipe_acc_tree #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter bit SAT    = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic                   clear,
  input  logic [CNT_W-1:0]       acc_len,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out,
  output logic                   ovf,
  output logic                   busy
);
  localparam int L     = $clog2(N_IN);
  localparam int SUM_W = DATA_W + L;

  logic [L-1:0]     stg_vld;
  logic [SUM_W-1:0] tree_sum;
  logic             tree_vld;

  // Stage s halves the word count and grows each word by one bit, so no sum is ever truncated.
  genvar s;
  generate
    for (s = 1; s <= L; s++) begin : g_stage
      localparam int NW = N_IN >> s;
      localparam int W  = DATA_W + s;

      logic [2*NW-1:0][W-2:0] src;
      logic                   src_vld;
      logic [NW-1:0][W-1:0]   dat_q;
      logic                   vld_q;

      if (s == 1) begin : g_src
        assign src     = in_data;
        assign src_vld = in_valid;
      end else begin : g_src
        assign src     = g_stage[s-1].dat_q;
        assign src_vld = g_stage[s-1].vld_q;
      end

      // Stage valid: dropped by reset or clear, otherwise follows the level below.
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= src_vld;
        end
      end

      // Stage data: pairwise sums, loaded only together with a valid word (no reset needed).
      always_ff @(posedge clk) begin
        if (src_vld) begin
          for (int j = 0; j < NW; j++) begin
            dat_q[j] <= {1'b0, src[2*j]} + {1'b0, src[2*j+1]};
          end
        end
      end

      assign stg_vld[s-1] = vld_q;

      if (s == L) begin : g_last
        assign tree_sum = dat_q[0];
        assign tree_vld = vld_q;
      end
    end
  endgenerate

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             flag_q, flag_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             outv_q, outv_d;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] eff_len;

  // One extra bit above the accumulator exposes the carry used for both clamping and the ovf flag.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W+1-SUM_W){1'b0}}, tree_sum};
  assign carry   = sum_ext[ACC_W];
  assign acc_add = (SAT && carry) ? '1 : sum_ext[ACC_W-1:0];
  assign cnt_inc = cnt_q + CNT_W'(1);
  // The window length is taken from acc_len only on a window's first add, so later changes wait for the next window.
  assign eff_len = (cnt_q != '0) ? len_q : ((acc_len == '0) ? CNT_W'(1) : acc_len);

  // Next-state for the window: clear wins over completion, completion restarts the window with no bubble.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    flag_d = flag_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    outv_d = 1'b0;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (tree_vld) begin
      if (cnt_inc == eff_len) begin
        out_d  = acc_add;
        ovf_d  = flag_q | carry;
        outv_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
        flag_d = 1'b0;
      end else begin
        acc_d  = acc_add;
        cnt_d  = cnt_inc;
        len_d  = eff_len;
        flag_d = flag_q | carry;
      end
    end
  end

  // Window and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      flag_q <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      outv_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      flag_q <= flag_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      outv_q <= outv_d;
    end
  end

  assign out_valid = outv_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign busy      = (|stg_vld) | (cnt_q != '0);

endmodule

// File: tb/tb_pipe_acc_tree.sv
// tb_pipe_acc_tree: drives a saturating and a wrapping pipe_acc_tree with identical stimulus.
// Latency: expected results come from a window-level model (queued lane sums, plain integer totals).
// Backpressure: none; the bench steps one clock per stimulus call.
module tb_pipe_acc_tree;
  logic        clk = 1'b0;
  logic        rst, in_valid, clear;
  logic [31:0] in_data;
  logic [7:0]  acc_len;
  logic        ov1, ov0, of1, of0, bz1, bz0;
  logic [15:0] o1, o0;

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] o;
    logic        v;
  } res_t;

  res_t obs1[$], obs0[$], exp1[$], exp0[$];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          due_q[$];
  longint      sum_q[$];
  longint      tot = 0;
  int          cnt = 0;
  int          mlen = 1;
  logic [15:0] m_out1 = '0, m_out0 = '0;
  logic        m_ovf1 = 1'b0, m_ovf0 = 1'b0, m_pv = 1'b0, m_busy = 1'b0;

  always #5 clk = ~clk;

  pipe_acc_tree #(.N_IN(4), .DATA_W(8), .ACC_W(16), .SAT(1'b1), .CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .acc_len(acc_len), .out_valid(ov1), .out(o1), .ovf(of1), .busy(bz1)
  );

  pipe_acc_tree #(.N_IN(4), .DATA_W(8), .ACC_W(16), .SAT(1'b0), .CNT_W(8)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .acc_len(acc_len), .out_valid(ov0), .out(o0), .ovf(of0), .busy(bz0)
  );

  // Record every result pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (ov1 === 1'b1) obs1.push_back({32'(cyc), o1, of1});
    if (ov0 === 1'b1) obs0.push_back({32'(cyc), o0, of0});
  end

  function automatic longint lane_sum(input logic [31:0] d);
    return longint'(d[7:0]) + longint'(d[15:8]) + longint'(d[23:16]) + longint'(d[31:24]);
  endfunction

  // One clock: apply inputs, then advance the window model for that edge.
  task automatic step(input logic v, input logic [31:0] d, input logic clr,
                      input int len, input logic r);
    longint s;
    in_valid = v; in_data = d; clear = clr; acc_len = 8'(len); rst = r;
    @(posedge clk);
    m_pv = 1'b0;
    if (!r || clr) begin
      due_q.delete(); sum_q.delete(); tot = 0; cnt = 0;
      if (!r) begin
        m_out1 = '0; m_out0 = '0; m_ovf1 = 1'b0; m_ovf0 = 1'b0;
      end
    end else begin
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        s = sum_q.pop_front();
        void'(due_q.pop_front());
        if (cnt == 0) mlen = (len == 0) ? 1 : len;
        tot += s;
        cnt++;
        if (cnt == mlen) begin
          m_out1 = (tot > 65535) ? 16'hFFFF : 16'(tot);
          m_out0 = 16'(tot % 65536);
          m_ovf1 = (tot > 65535);
          m_ovf0 = m_ovf1;
          m_pv   = 1'b1;
          exp1.push_back({32'(cyc + 1), m_out1, m_ovf1});
          exp0.push_back({32'(cyc + 1), m_out0, m_ovf0});
          tot = 0;
          cnt = 0;
        end
      end
      if (v) begin
        due_q.push_back(cyc + 2);
        sum_q.push_back(lane_sum(d));
      end
    end
    m_busy = (due_q.size() != 0) || (cnt != 0);
    cyc++;
    #1;
  endtask

  task automatic clear_q();
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete();
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 32'hFFFFFFFF, 1'b0, 1, 1'b0);
    n_chk++;
    if ({ov1, ov0, of1, of0, bz1, bz0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got vld=%b%b ovf=%b%b busy=%b%b, required all 0", ov1, ov0, of1, of0, bz1, bz0);
    end
    n_chk++;
    if ({o1, o0} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %0d/%0d, required 0/0", o1, o0);
    end
    repeat (2) step(1'b0, 32'h0, 1'b0, 1, 1'b1);
  endtask

  task automatic test_basic();
    clear_q();
    repeat (3) step(1'b1, 32'h04030201, 1'b0, 3, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 3, 1'b1);
    n_chk++;
    if (o1 !== 16'd30 || of1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_held: got out=%0d ovf=%b, required out=30 ovf=0", o1, of1);
    end
    n_chk++;
    if (bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_busy: got %b, required 0", bz1);
    end
    n_chk++;
    if (obs1.size() != exp1.size() || obs0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d/%0d pulses, required %0d/%0d", obs1.size(), obs0.size(), exp1.size(), exp0.size());
    end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      n_chk++;
      if (obs1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL basic_sat[%0d]: got t=%0d out=%0d ovf=%b, required t=%0d out=%0d ovf=%b", i, obs1[i].t, obs1[i].o, obs1[i].v, exp1[i].t, exp1[i].o, exp1[i].v);
      end
    end
  endtask

  task automatic test_saturate();
    clear_q();
    repeat (100) step(1'b1, 32'hFFFFFFFF, 1'b0, 100, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 100, 1'b1);
    n_chk++;
    if (o1 !== 16'd65535 || of1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_result: got out=%0d ovf=%b, required out=65535 ovf=1", o1, of1);
    end
    n_chk++;
    if (o0 !== 16'd36464 || of0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_result: got out=%0d ovf=%b, required out=36464 ovf=1", o0, of0);
    end
    n_chk++;
    if (obs1.size() != exp1.size() || obs0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL sat_count: got %0d/%0d pulses, required %0d/%0d", obs1.size(), obs0.size(), exp1.size(), exp0.size());
    end
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      n_chk++;
      if (obs0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL sat_wrap[%0d]: got t=%0d out=%0d ovf=%b, required t=%0d out=%0d ovf=%b", i, obs0[i].t, obs0[i].o, obs0[i].v, exp0[i].t, exp0[i].o, exp0[i].v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [4];
    pat[0] = 32'h04030201; pat[1] = 32'h05050505; pat[2] = 32'h0A0A0505; pat[3] = 32'h0A0A0A0A;
    clear_q();
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 2, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 2, 1'b1);
    n_chk++;
    if (obs1.size() != 2 || exp1.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses, required 2 (model %0d)", obs1.size(), exp1.size());
    end
    if (obs1.size() >= 2) begin
      n_chk++;
      if (obs1[1].t - obs1[0].t !== 32'd2) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles, required 2", obs1[1].t - obs1[0].t);
      end
    end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      n_chk++;
      if (obs1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got t=%0d out=%0d ovf=%b, required t=%0d out=%0d ovf=%b", i, obs1[i].t, obs1[i].o, obs1[i].v, exp1[i].t, exp1[i].o, exp1[i].v);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    step(1'b1, 32'h01010102, 1'b0, 2, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
    step(1'b1, 32'h01020202, 1'b0, 2, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h03020301, 1'b0, 0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 0, 1'b1);
    end
    // Mid-window length change: first sample arrives while acc_len=3, then acc_len moves to 1.
    repeat (3) step(1'b1, 32'h04030201, 1'b0, 3, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    n_chk++;
    if (obs1.size() != exp1.size() || obs0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d/%0d pulses, required %0d/%0d", obs1.size(), obs0.size(), exp1.size(), exp0.size());
    end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      n_chk++;
      if (obs1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got t=%0d out=%0d ovf=%b, required t=%0d out=%0d ovf=%b", i, obs1[i].t, obs1[i].o, obs1[i].v, exp1[i].t, exp1[i].o, exp1[i].v);
      end
    end
  endtask

  task automatic test_clear_and_reset();
    clear_q();
    repeat (3) step(1'b1, 32'h04030201, 1'b0, 3, 1'b1);
    step(1'b0, 32'h0, 1'b0, 3, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 3, 1'b1);
    n_chk++;
    if (ov1 !== 1'b0 || o1 !== m_out1 || of1 !== m_ovf1) begin
      n_fail++;
      $display("FAIL clear_hold: got vld=%b out=%0d ovf=%b, required vld=0 out=%0d ovf=%b", ov1, o1, of1, m_out1, m_ovf1);
    end
    repeat (3) step(1'b1, 32'h04030201, 1'b0, 3, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 3, 1'b1);
    repeat (2) step(1'b1, 32'hFFFFFFFF, 1'b0, 4, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 4, 1'b0);
    n_chk++;
    if ({ov1, o1, of1, bz1, ov0, o0, of0, bz0} !== {1'b0, m_out1, m_ovf1, m_busy, 1'b0, m_out0, m_ovf0, m_busy}) begin
      n_fail++;
      $display("FAIL reset_midwin: got out=%0d/%0d ovf=%b%b busy=%b%b, required out=%0d ovf=%b busy=%b", o1, o0, of1, of0, bz1, bz0, m_out1, m_ovf1, m_busy);
    end
    repeat (6) step(1'b0, 32'h0, 1'b0, 4, 1'b1);
    n_chk++;
    if (obs1.size() != exp1.size() || obs0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL clear_count: got %0d/%0d pulses, required %0d/%0d", obs1.size(), obs0.size(), exp1.size(), exp0.size());
    end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      n_chk++;
      if (obs1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL clear[%0d]: got t=%0d out=%0d ovf=%b, required t=%0d out=%0d ovf=%b", i, obs1[i].t, obs1[i].o, obs1[i].v, exp1[i].t, exp1[i].o, exp1[i].v);
      end
    end
  endtask

  task automatic test_random();
    int len = 3;
    clear_q();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 6);
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 29) == 0, len,
           $urandom_range(0, 149) != 0);
      n_chk++;
      if ({ov1, o1, of1, bz1} !== {m_pv, m_out1, m_ovf1, m_busy}) begin
        n_fail++;
        $display("FAIL rand_sat@%0d: got vld=%b out=%0d ovf=%b busy=%b, required vld=%b out=%0d ovf=%b busy=%b", cyc, ov1, o1, of1, bz1, m_pv, m_out1, m_ovf1, m_busy);
      end
      n_chk++;
      if ({ov0, o0, of0, bz0} !== {m_pv, m_out0, m_ovf0, m_busy}) begin
        n_fail++;
        $display("FAIL rand_wrap@%0d: got vld=%b out=%0d ovf=%b busy=%b, required vld=%b out=%0d ovf=%b busy=%b", cyc, ov0, o0, of0, bz0, m_pv, m_out0, m_ovf0, m_busy);
      end
    end
    repeat (5) step(1'b0, 32'h0, 1'b0, len, 1'b1);
    n_chk++;
    if (obs1.size() != exp1.size() || obs0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d/%0d pulses, required %0d/%0d", obs1.size(), obs0.size(), exp1.size(), exp0.size());
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; acc_len = 8'd1;
    #1;
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_gaps();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
